// File: rtl/rv_store_unit.sv
// Store-side data-memory master: aligns SB/SH/SW data to byte lanes and runs one req/ack write at a time.
// Optional RV_STORE_MISALIGN_TRAP_EN: misaligned SH/SW are dropped with an error instead of being issued.
module rv_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  output logic        o_mem_req,
  output logic [29:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_cause
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          dec_illegal;
  logic          dec_trap;
  logic [31:0]   dec_wdata;
  logic [3:0]    dec_be;

  assign o_ready = (state == IDLE) | ((state == BUSY) & i_mem_ack);
  assign accept  = i_valid & o_ready;

  always_comb begin
    dec_illegal = 1'b0;
    dec_trap    = 1'b0;
    dec_wdata   = i_data;
    dec_be      = 4'b1111;
    case (i_funct3)
      3'b000: begin
        dec_wdata = {4{i_data[7:0]}};
        dec_be    = 4'b0001 << i_addr[1:0];
      end
      3'b001: begin
        dec_wdata = {2{i_data[15:0]}};
        dec_be    = i_addr[1] ? 4'b1100 : 4'b0011;
`ifdef RV_STORE_MISALIGN_TRAP_EN
        dec_trap  = i_addr[0];
`endif
      end
      3'b010: begin
`ifdef RV_STORE_MISALIGN_TRAP_EN
        dec_trap  = |i_addr[1:0];
`endif
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_err_cause <= 2'b00;
    end else begin
      o_done <= 1'b0;
      case (state)
        BUSY: begin
          if (i_mem_ack) begin
            o_done    <= 1'b1;
            o_mem_req <= 1'b0;
            state     <= IDLE;
          end else if ((TIMEOUT > 0) && (cnt == LIMIT)) begin
            o_mem_req   <= 1'b0;
            o_err       <= 1'b1;
            o_err_cause <= 2'b10;
            state       <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          // A faulting store accepted on an ack cycle waits one cycle so its error follows the done pulse
          if (!o_err) begin
            o_err <= 1'b1;
          end else begin
            o_err       <= 1'b0;
            o_err_cause <= 2'b00;
            state       <= IDLE;
          end
        end
        default: ;
      endcase

      if (accept) begin
        cnt <= '0;
        if (dec_illegal || dec_trap) begin
          o_mem_req   <= 1'b0;
          o_err       <= (state != BUSY);
          o_err_cause <= dec_illegal ? 2'b11 : 2'b01;
          state       <= ERR;
        end else begin
          o_mem_req   <= 1'b1;
          o_mem_addr  <= i_addr[31:2];
          o_mem_wdata <= dec_wdata;
          o_mem_be    <= dec_be;
          state       <= BUSY;
        end
      end
    end
  end

endmodule
